oam_dma_ctrl: RTL
=================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter OAM_BYTES, default 160: number of bytes copied per transfer.
REQ-002 Parameter SLOT_CYCLES, default 4: clocks per byte slot (one machine cycle); SHALL be >= 2.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port reg_we  input  1: CPU write strobe to the DMA register (0xFF46), one clk wide.
REQ-006 Port reg_wdata  input  8: source high byte written by the CPU.
REQ-007 Port reg_rdata  output  8: current DMA register contents.
REQ-008 Port src_addr  output  16: source read address.
REQ-009 Port src_re  output  1: source read strobe; src_rdata is valid exactly one clk later.
REQ-010 Port src_rdata  input  8: source read data.
REQ-011 Port oam_addr  output  8: OAM byte index (0..OAM_BYTES-1).
REQ-012 Port oam_we  output  1: OAM write strobe.
REQ-013 Port oam_wdata  output  8: OAM write data.
REQ-014 Port busy  output  1: transfer in progress; CPU bus accesses outside HRAM are blocked while high.

Function
REQ-015 FSM states SHALL be IDLE, START, XFER.
REQ-016 In IDLE, reg_we high at a rising edge SHALL latch reg_wdata into the register, clear byte index to 0, clear slot counter to 0 and enter START.
REQ-017 START SHALL last exactly one slot (SLOT_CYCLES clks) with src_re=0 and oam_we=0, then enter XFER.
REQ-018 In XFER, slot cycle 0 of byte i SHALL assert src_re for one clk with src_addr = {register, i[7:0]}.
REQ-019 In XFER, slot cycle 1 of byte i SHALL assert oam_we for one clk with oam_addr = i and oam_wdata = src_rdata captured from the preceding cycle.
REQ-020 src_re and oam_we SHALL be low in all other slot cycles; src_addr and oam_addr hold their last values when strobes are low.
REQ-021 After the last slot cycle of byte OAM_BYTES-1, the FSM SHALL return to IDLE.
REQ-022 busy SHALL be high in START and XFER, low in IDLE: exactly (OAM_BYTES+1)*SLOT_CYCLES clks per uninterrupted transfer (644 with defaults), starting the clk after the accepting edge.
REQ-023 reg_we while busy SHALL restart: latch new value, index 0, slot counter 0, enter START; bytes already written are not undone.
REQ-024 reg_we on the final clk of the final slot SHALL be treated as a restart; busy stays high with no low cycle.
REQ-025 reg_rdata SHALL always return the last latched value, independent of FSM state.
REQ-026 Byte index SHALL be 8 bits and never exceed OAM_BYTES-1; source low byte equals index (no carry into high byte).
REQ-027 Any register value 0x00..0xFF SHALL be accepted; no address remapping is done here.

Reset
REQ-028 reset high SHALL immediately force IDLE, busy=0, src_re=0, oam_we=0, register=0x00, reg_rdata=0x00, index=0, src_addr=0x0000, oam_addr=0x00, oam_wdata=0x00.
REQ-029 reset asserted mid-transfer SHALL abort it with no further strobes; after deassertion the block stays idle until the next reg_we.

Verification
REQ-030 reg_we with 0xC1, source model returns low address byte XOR 0x5A -> OAM[i] = i^0x5A for i=0..159; busy high exactly 644 clks; exactly 160 src_re and 160 oam_we pulses.
REQ-031 Same stimulus -> first src_re at clk 5 after the accepting edge with src_addr=0xC100; first oam_we at clk 6, oam_addr=0x00; last oam_we oam_addr=0x9F, src_addr=0xC19F.
REQ-032 reg_we 0xC1, then reg_we 0xD0 after byte 50 is written -> OAM[0..50] from 0xC1xx, then new START slot and full 160 bytes from 0xD0xx; reg_rdata=0xD0; busy never drops between.
REQ-033 reset pulsed during byte 80 -> busy, src_re, oam_we low within the same cycle; reg_rdata=0x00; no strobes for 100 clks afterward.
REQ-034 reg_we on final clk of the final slot -> busy remains continuously high and a second full transfer of 160 bytes follows.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies OAM_BYTES bytes from {reg, index} into OAM,
// one byte per machine-cycle slot, after a one-slot start delay.
module oam_dma_ctrl #(
    parameter int OAM_BYTES   = 160,
    parameter int SLOT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic [15:0] src_addr,
    output logic        src_re,
    input  logic [7:0]  src_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    output logic        busy
);

    localparam int SW = $clog2(SLOT_CYCLES);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
    localparam logic [7:0] IDX_LAST = 8'(OAM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state, state_n;
    logic [SW-1:0] slot, slot_n;
    logic [7:0]    idx, idx_n;
    logic [7:0]    dma_reg, dma_reg_n;
    logic [15:0]   src_q;
    logic [7:0]    oaddr_q;
    logic [7:0]    odata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            slot    <= '0;
            idx     <= '0;
            dma_reg <= '0;
            src_q   <= '0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            state   <= state_n;
            slot    <= slot_n;
            idx     <= idx_n;
            dma_reg <= dma_reg_n;
            if (src_re) src_q <= src_addr;
            if (oam_we) begin
                oaddr_q <= idx;
                odata_q <= src_rdata;
            end
        end
    end

    always_comb begin
        state_n   = state;
        slot_n    = slot;
        idx_n     = idx;
        dma_reg_n = dma_reg;
        src_re    = 1'b0;
        oam_we    = 1'b0;
        case (state)
            IDLE: ;
            START: begin
                if (slot == SLOT_LAST) begin
                    slot_n  = '0;
                    state_n = XFER;
                end else begin
                    slot_n = slot + SW'(1);
                end
            end
            XFER: begin
                src_re = (slot == '0);
                oam_we = (slot == SW'(1));
                if (slot == SLOT_LAST) begin
                    slot_n = '0;
                    if (idx == IDX_LAST) state_n = IDLE;
                    else idx_n = idx + 8'd1;
                end else begin
                    slot_n = slot + SW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // A register write always wins, including on the final slot clk.
        if (reg_we) begin
            dma_reg_n = reg_wdata;
            idx_n     = '0;
            slot_n    = '0;
            state_n   = START;
        end
    end

    // Addresses/data show live values during a strobe and hold otherwise.
    assign busy      = (state != IDLE);
    assign reg_rdata = dma_reg;
    assign src_addr  = src_re ? {dma_reg, idx} : src_q;
    assign oam_addr  = oam_we ? idx : oaddr_q;
    assign oam_wdata = oam_we ? src_rdata : odata_q;

endmodule
